reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Central reset controller for the SoC. It sits between the clock generator, the reset-button debouncer and the SoC. It also takes a software reset request from the SoC. The block holds the SoC in reset until the PLL lock has been stable for a programmable time, then stretches reset for a fixed number of cycles. Afterwards it re-enters the sequence on lock loss, button press or software request, and records why the last reset happened.

## Interface
- LOCK_STABLE_CYCLES, default 16: consecutive synchronized-lock cycles required before leaving WAIT_LOCK (≥1)
- HOLD_CYCLES, default 8: cycles soc_reset_out is held low in HOLD (≥1)
- clk_in  input  1  system clock (PLL slow clock); one clock domain
- reset_in  input  1  asynchronous, active-low reset for all block state
- locked_in  input  1  PLL lock, asynchronous to clk_in, synchronized internally
- btn_pulse_in  input  1  one-cycle pulse from the reset-button debouncer (rising edge)
- sw_req_in  input  1  one-cycle software reset request from the SoC
- soc_reset_out  output  1  registered active-low SoC reset (0 = SoC in reset)
- cause_out  output  2  reset cause of the most recent reset, type reset_cause_t
- reset_count_out  output  8  saturating count of resets since reset_in

## Operation
- Reset values (reset_in low): state WAIT_LOCK, soc_reset_out 0, cause_out POWER_ON, reset_count_out 0, both internal counters 0, synchronizer flops 0.
- Cause encoding (reset_cause_t): POWER_ON=0, LOCK_LOSS=1, BUTTON=2, SOFTWARE=3.
- locked_sync is locked_in delayed by a 2-flop synchronizer.
- **WAIT_LOCK:**
  - soc_reset_out = 0.
  - A stable counter increments on each edge that samples locked_sync=1. An edge that samples locked_sync=0 clears it.
  - On the edge where locked_sync=1 and the counter = LOCK_STABLE_CYCLES-1: go to HOLD and clear the hold counter.
  - btn_pulse_in sets cause BUTTON; state and counter are unaffected.
  - sw_req_in is ignored.
- **HOLD:**
  - soc_reset_out = 0.
  - The hold counter increments on each edge.
  - On the edge where the counter = HOLD_CYCLES-1: go to RUN and set soc_reset_out to 1 on the same edge.
  - locked_sync=0: go to WAIT_LOCK, clear the stable counter, set cause LOCK_LOSS.
  - btn_pulse_in: clear the hold counter (restart HOLD) and set cause BUTTON.
  - sw_req_in is ignored.
- **RUN:**
  - soc_reset_out = 1.
  - locked_sync=0: go to WAIT_LOCK and set cause LOCK_LOSS.
  - Otherwise btn_pulse_in: go to HOLD and set cause BUTTON.
  - Otherwise sw_req_in: go to HOLD and set cause SOFTWARE.
  - Each of these exits drives soc_reset_out to 0 on the same edge and increments reset_count_out, saturating at 255.
- **Priority** on simultaneous events: lock loss > button > software. Only one cause is recorded per edge.
- cause_out is sticky; it changes only on the events listed above.
- Counter widths: $clog2 of the respective parameter + 1 bits. Counters never wrap past their terminal value.
- Asserting reset_in at any time (mid-HOLD, mid-RUN) returns all state to the reset values immediately (asynchronously).

## Timing
- locked_in rise → locked_sync high: 2 edges.
- locked_in fall in RUN → soc_reset_out low: 3rd edge after the fall (2 synchronizer edges + 1 state edge).
- btn_pulse_in/sw_req_in sampled high in RUN → soc_reset_out low on that same edge, then exactly HOLD_CYCLES cycles low.
- Power-on with locked_in held high: soc_reset_out rises at edge 2 + LOCK_STABLE_CYCLES + HOLD_CYCLES after reset_in release.
- All outputs are flop outputs; no combinational path from inputs to outputs.

## Structure
- Package reset_pkg holds:
  - reset_cause_t (2-bit enum, values above)
  - seq_state_t (WAIT_LOCK, HOLD, RUN)
  - the reset_count width constant (8)
- One sub-module, sync_2ff:
  - 2-flop synchronizer on clk_in
  - asynchronous active-low reset to 0
  - instantiated once for locked_in

## Test plan
- **Power-on:** LOCK_STABLE_CYCLES=4, HOLD_CYCLES=3, locked_in=1, release reset_in before edge 1 → soc_reset_out low through edge 8, high at edge 9; cause_out=0; reset_count_out=0.
- **Lock glitch:** in WAIT_LOCK, locked_in low for 1 cycle after 3 stable cycles → stable counter clears; soc_reset_out rises only after 4 further stable cycles + 3 HOLD cycles.
- **Button in RUN:** one-cycle btn_pulse_in → soc_reset_out low on that edge for exactly 3 cycles; cause_out=2; reset_count_out=1.
- **Simultaneous requests:** btn_pulse_in and sw_req_in in the same RUN cycle → cause_out=2, count +1. Then sw_req_in alone later → cause_out=3, count +1.
- **Lock loss:** locked_in falls in RUN → soc_reset_out low 3 edges later, state WAIT_LOCK, cause_out=1. Lock loss mid-HOLD → back to WAIT_LOCK, cause_out=1.
- **Saturation and reset:**
  - 260 software requests → reset_count_out=255.
  - Asserting reset_in mid-HOLD → all outputs at reset values immediately.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package reset_pkg;

  localparam int unsigned RESET_COUNT_W = 8;

  typedef enum logic [1:0] {
    POWER_ON  = 2'd0,
    LOCK_LOSS = 2'd1,
    BUTTON    = 2'd2,
    SOFTWARE  = 2'd3
  } reset_cause_t;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] v);
    if (v == {RESET_COUNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(RESET_COUNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_in domain.
module sync_2ff (
  input  logic clk_in,
  input  logic reset_in,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  // synchronizer chain, cleared to 0 by the async reset
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset controller: waits for stable PLL lock, stretches reset, then
// re-sequences on lock loss, button or software request and records the cause.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES        = 8
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     locked_in,
  input  logic                     btn_pulse_in,
  input  logic                     sw_req_in,
  output logic                     soc_reset_out,
  output logic [1:0]               cause_out,
  output logic [RESET_COUNT_W-1:0] reset_count_out
);

  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

  logic                     locked_sync;
  seq_state_t               state_q,  state_d;
  logic [SW-1:0]            stable_q, stable_d;
  logic [HW-1:0]            hold_q,   hold_d;
  reset_cause_t             cause_q,  cause_d;
  logic [RESET_COUNT_W-1:0] count_q,  count_d;
  logic                     soc_q,    soc_d;

  sync_2ff u_lock_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .d_in     (locked_in),
    .q_out    (locked_sync)
  );

  // next-state logic; lock loss outranks button, button outranks software
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    hold_d   = hold_q;
    cause_d  = cause_q;
    count_d  = count_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!locked_sync) begin
          stable_d = {SW{1'b0}};
        end else if (stable_q == STABLE_LAST) begin
          state_d = HOLD;
          hold_d  = {HW{1'b0}};
        end else begin
          stable_d = stable_q + {{(SW-1){1'b0}}, 1'b1};
        end
        if (btn_pulse_in) begin
          cause_d = BUTTON;
        end else begin
          cause_d = cause_q;
        end
      end
      HOLD: begin
        if (!locked_sync) begin
          state_d  = WAIT_LOCK;
          stable_d = {SW{1'b0}};
          cause_d  = LOCK_LOSS;
        end else if (btn_pulse_in) begin
          hold_d  = {HW{1'b0}};
          cause_d = BUTTON;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + {{(HW-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (!locked_sync) begin
          state_d  = WAIT_LOCK;
          stable_d = {SW{1'b0}};
          cause_d  = LOCK_LOSS;
          count_d  = sat_inc(count_q);
        end else if (btn_pulse_in) begin
          state_d = HOLD;
          hold_d  = {HW{1'b0}};
          cause_d = BUTTON;
          count_d = sat_inc(count_q);
        end else if (sw_req_in) begin
          state_d = HOLD;
          hold_d  = {HW{1'b0}};
          cause_d = SOFTWARE;
          count_d = sat_inc(count_q);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d  = WAIT_LOCK;
        stable_d = {SW{1'b0}};
        hold_d   = {HW{1'b0}};
      end
    endcase
    // SoC reset is released exactly while the next state is RUN
    soc_d = (state_d == RUN);
  end

  // state and output registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= WAIT_LOCK;
      stable_q <= {SW{1'b0}};
      hold_q   <= {HW{1'b0}};
      cause_q  <= POWER_ON;
      count_q  <= {RESET_COUNT_W{1'b0}};
      soc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
      soc_q    <= soc_d;
    end
  end

  assign soc_reset_out   = soc_q;
  assign cause_out       = cause_q;
  assign reset_count_out = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_STABLE_CYCLES=4, HOLD_CYCLES=3.
module tb_reset_sequencer;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       locked_in;
  logic       btn_pulse_in;
  logic       sw_req_in;
  logic       soc_reset_out;
  logic [1:0] cause_out;
  logic [7:0] reset_count_out;

  int total = 0;
  int bad   = 0;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (4),
    .HOLD_CYCLES        (3)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .locked_in       (locked_in),
    .btn_pulse_in    (btn_pulse_in),
    .sw_req_in       (sw_req_in),
    .soc_reset_out   (soc_reset_out),
    .cause_out       (cause_out),
    .reset_count_out (reset_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_soc(input string tag, input logic exp);
    chk(tag, 32'(soc_reset_out), 32'(exp));
  endtask

  initial begin
    reset_in     = 1'b1;
    locked_in    = 1'b1;
    btn_pulse_in = 1'b0;
    sw_req_in    = 1'b0;
    #1 reset_in = 1'b0;
    #1;
    chk_soc("rst_soc", 1'b0);
    chk("rst_cause", 32'(cause_out), 32'd0);
    chk("rst_count", 32'(reset_count_out), 32'd0);
    tick();
    tick();

    // power-on with lock high: release at edge 9
    reset_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_soc("po_soc", (i == 9));
    end
    chk("po_cause", 32'(cause_out), 32'd0);
    chk("po_count", 32'(reset_count_out), 32'd0);

    // lock glitch after three stable cycles restarts the stable count
    reset_in = 1'b0;
    tick();
    reset_in = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 3) locked_in = 1'b0;
      if (i == 4) locked_in = 1'b1;
      chk_soc("glitch_soc", (i >= 13));
    end

    // button in RUN
    btn_pulse_in = 1'b1;
    tick();
    btn_pulse_in = 1'b0;
    chk_soc("btn_soc0", 1'b0);
    chk("btn_cause", 32'(cause_out), 32'd2);
    chk("btn_count", 32'(reset_count_out), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_soc("btn_hold", (i == 3));
    end

    // simultaneous button and software: button wins
    btn_pulse_in = 1'b1;
    sw_req_in    = 1'b1;
    tick();
    btn_pulse_in = 1'b0;
    sw_req_in    = 1'b0;
    chk_soc("both_soc0", 1'b0);
    chk("both_cause", 32'(cause_out), 32'd2);
    chk("both_count", 32'(reset_count_out), 32'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_soc("both_hold", (i == 3));
    end

    // software alone
    sw_req_in = 1'b1;
    tick();
    sw_req_in = 1'b0;
    chk_soc("sw_soc0", 1'b0);
    chk("sw_cause", 32'(cause_out), 32'd3);
    chk("sw_count", 32'(reset_count_out), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_soc("sw_hold", (i == 3));
    end

    // lock loss in RUN: reset asserted on the third edge
    locked_in = 1'b0;
    tick();
    chk_soc("ll_soc1", 1'b1);
    tick();
    chk_soc("ll_soc2", 1'b1);
    tick();
    chk_soc("ll_soc3", 1'b0);
    chk("ll_cause", 32'(cause_out), 32'd1);
    chk("ll_count", 32'(reset_count_out), 32'd4);
    tick();
    tick();

    // button while waiting for lock only updates the cause
    btn_pulse_in = 1'b1;
    tick();
    btn_pulse_in = 1'b0;
    chk("wl_btn_cause", 32'(cause_out), 32'd2);
    chk_soc("wl_btn_soc", 1'b0);
    chk("wl_btn_count", 32'(reset_count_out), 32'd4);

    // regain lock, enter HOLD at edge 6, then lose lock mid-HOLD
    locked_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_soc("relock_soc", 1'b0);
    end
    locked_in = 1'b0;
    tick();
    tick();
    chk("hl_cause_pre", 32'(cause_out), 32'd2);
    tick();
    chk_soc("hl_soc", 1'b0);
    chk("hl_cause", 32'(cause_out), 32'd1);
    chk("hl_count", 32'(reset_count_out), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_soc("hl_stay_low", 1'b0);
    end

    // back to RUN
    locked_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_soc("rerun_soc", (i == 9));
    end

    // saturation of the reset counter
    for (int k = 0; k < 260; k++) begin
      sw_req_in = 1'b1;
      tick();
      sw_req_in = 1'b0;
      tick();
      tick();
      tick();
      if (k == 250) chk("sat_reach", 32'(reset_count_out), 32'd255);
    end
    chk("sat_count", 32'(reset_count_out), 32'd255);
    chk("sat_cause", 32'(cause_out), 32'd3);
    chk_soc("sat_soc", 1'b1);

    // asynchronous reset mid-HOLD
    sw_req_in = 1'b1;
    tick();
    sw_req_in = 1'b0;
    tick();
    chk_soc("mh_soc_pre", 1'b0);
    #2 reset_in = 1'b0;
    #1;
    chk_soc("mh_rst_soc", 1'b0);
    chk("mh_rst_cause", 32'(cause_out), 32'd0);
    chk("mh_rst_count", 32'(reset_count_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
